// File: rtl/ctrl_decode_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_decode_pipe
//   Registered RV32I control decoder feeding the ID/EX pipeline register.
//   Decodes the full instruction (opcode, funct3, funct7), flags illegal
//   encodings, inserts one bubble per load-use hazard and sequences
//   multi-cycle M-extension operations, stalling IF/ID while they run.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid/id_instr live instruction in ID
//   stall_in          downstream stall: freeze the EX register and MDU counter
//   flush             redirect: kill ID and EX, abort any MDU sequence
//   id_stall          combinational: hold PC and IF/ID this cycle
//   ex_*              ID/EX control register contents
//   ex_mdu_op         EX holds a MUL/DIV/REM op
//   ex_mdu_done       registered 1-cycle pulse in the final MDU cycle
//   ex_illegal        EX holds an illegal instruction
// ---------------------------------------------------------------------------
module ctrl_decode_pipe #(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_alusrc,
  output logic        ex_pctoregsrc,
  output logic        ex_rdsrc,
  output logic        ex_mread,
  output logic        ex_mwrite,
  output logic        ex_memtoreg,
  output logic [2:0]  ex_aluop,
  output logic [1:0]  ex_branchctrl,
  output logic [2:0]  ex_immtype,
  output logic [4:0]  ex_rd,
  output logic        ex_mdu_op,
  output logic        ex_mdu_done,
  output logic        ex_illegal
);

  // Counter must hold LAT-1 for whichever latency is larger.
  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Field order matches the decode table so rows can be written as literals.
  typedef struct packed {
    logic       regwrite;
    logic [2:0] aluop;
    logic       alusrc;
    logic [1:0] branchctrl;
    logic       pctoregsrc;
    logic       rdsrc;
    logic       mread;
    logic       mwrite;
    logic       memtoreg;
    logic [2:0] immtype;
  } ctrl_bits_t;

  typedef struct packed {
    ctrl_bits_t ctrl;
    logic [4:0] rd;
    logic       mdu;
    logic       illegal;
  } ex_ctrl_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign funct7 = id_instr[31:25];

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  ex_ctrl_t dec;
  logic     uses_rs1, uses_rs2, legal;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec      = '0;
    dec.rd   = rd;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_R: begin
        dec.ctrl = 15'b1_000_0_00_1_1_0_0_0_111;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (ENABLE_M && funct7 == 7'b0000001) begin
          dec.mdu = 1'b1;
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          legal = 1'b0;
        end
      end
      OP_S: begin
        dec.ctrl = 15'b0_010_1_00_1_1_0_1_0_010;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_B: begin
        dec.ctrl = 15'b0_011_0_01_0_0_0_0_0_011;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_AUIPC: dec.ctrl = 15'b1_100_1_00_0_0_0_0_0_000;
      OP_LUI:   dec.ctrl = 15'b1_100_1_00_0_1_0_0_0_000;
      OP_JAL:   dec.ctrl = 15'b1_101_1_10_1_0_0_0_0_100;
      OP_LOAD: begin
        dec.ctrl = 15'b1_001_1_00_0_1_1_0_1_001;
        uses_rs1 = 1'b1;
      end
      OP_OPIMM: begin
        dec.ctrl = 15'b1_110_1_00_0_1_0_0_0_001;
        uses_rs1 = 1'b1;
      end
      OP_JALR: begin
        dec.ctrl = 15'b1_111_1_11_1_0_0_0_0_001;
        uses_rs1 = 1'b1;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings carry only the flag; nothing may write state.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
    // An empty ID slot decodes to all-zero so a bubble is never an MDU op.
    if (!id_valid) begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // EX register, MDU sequencer and stall control
  // ---------------------------------------------------------------------
  ex_ctrl_t         ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;
  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             mdu_busy, load_use;

  // In BUSY with cnt==0 the op is in its final cycle and ID may advance.
  assign mdu_busy = (state_q == BUSY) && (cnt_q != '0);

  assign load_use = ex_valid_q && ex_q.ctrl.mread && (ex_q.rd != 5'd0) && id_valid &&
                    ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    id_stall   = 1'b0;

    if (flush) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (stall_in) begin
      id_stall = 1'b1;
      done_d   = done_q;
    end else if (mdu_busy) begin
      id_stall = 1'b1;
      cnt_d    = cnt_q - CNT_ONE;
      done_d   = (cnt_q == CNT_ONE);
    end else if (load_use) begin
      id_stall   = 1'b1;
      ex_d       = '0;
      ex_valid_d = 1'b0;
      state_d    = IDLE;
      cnt_d      = '0;
    end else begin
      ex_d       = dec;
      ex_valid_d = id_valid;
      state_d    = IDLE;
      cnt_d      = '0;
      if (dec.mdu) begin
        cnt_d = funct3[2] ? DIV_CNT : MUL_CNT;
        // Single-cycle ops never enter BUSY; their done pulse follows the load.
        if (cnt_d == '0) done_d  = 1'b1;
        else             state_d = BUSY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_regwrite   = ex_q.ctrl.regwrite;
  assign ex_alusrc     = ex_q.ctrl.alusrc;
  assign ex_pctoregsrc = ex_q.ctrl.pctoregsrc;
  assign ex_rdsrc      = ex_q.ctrl.rdsrc;
  assign ex_mread      = ex_q.ctrl.mread;
  assign ex_mwrite     = ex_q.ctrl.mwrite;
  assign ex_memtoreg   = ex_q.ctrl.memtoreg;
  assign ex_aluop      = ex_q.ctrl.aluop;
  assign ex_branchctrl = ex_q.ctrl.branchctrl;
  assign ex_immtype    = ex_q.ctrl.immtype;
  assign ex_rd         = ex_q.rd;
  assign ex_mdu_op     = ex_q.mdu;
  assign ex_mdu_done   = done_q;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_decode_pipe
//   Directed-vector bench for ctrl_decode_pipe. A second instance built with
//   ENABLE_M=0 shares the stimulus and is checked only on M-extension
//   encodings.
// ---------------------------------------------------------------------------
module tb_ctrl_decode_pipe;

  localparam logic [31:0] I_ADD_3_1_2  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADD_6_5_2  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_ADD_6_0_2  = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_LW_5       = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW_0       = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_LUI_5      = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_DIV        = 32'h029443B3; // div  x7,x8,x9
  localparam logic [31:0] I_MUL        = 32'h02C58533; // mul  x10,x11,x12
  localparam logic [31:0] I_BAD_OP     = 32'h000003FF; // opcode 0x7F, rd=7
  localparam logic [31:0] I_JALR_F1    = 32'h000110E7; // jalr, funct3=001
  localparam logic [31:0] I_JALR       = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] I_SW         = 32'h0020A223; // sw   x2,4(x1)

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall_in, flush;
  logic [31:0] id_instr;

  logic        id_stall, ex_valid, ex_regwrite, ex_alusrc, ex_pctoregsrc, ex_rdsrc;
  logic        ex_mread, ex_mwrite, ex_memtoreg, ex_mdu_op, ex_mdu_done, ex_illegal;
  logic [2:0]  ex_aluop, ex_immtype;
  logic [1:0]  ex_branchctrl;
  logic [4:0]  ex_rd;

  logic        nm_id_stall, nm_ex_valid, nm_ex_regwrite, nm_ex_alusrc, nm_ex_pctoregsrc;
  logic        nm_ex_rdsrc, nm_ex_mread, nm_ex_mwrite, nm_ex_memtoreg, nm_ex_mdu_op;
  logic        nm_ex_mdu_done, nm_ex_illegal;
  logic [2:0]  nm_ex_aluop, nm_ex_immtype;
  logic [1:0]  nm_ex_branchctrl;
  logic [4:0]  nm_ex_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.ENABLE_M(1'b1), .MUL_LAT(2), .DIV_LAT(33)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_in(stall_in), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_pctoregsrc(ex_pctoregsrc),
    .ex_rdsrc(ex_rdsrc), .ex_mread(ex_mread), .ex_mwrite(ex_mwrite),
    .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop), .ex_branchctrl(ex_branchctrl),
    .ex_immtype(ex_immtype), .ex_rd(ex_rd), .ex_mdu_op(ex_mdu_op),
    .ex_mdu_done(ex_mdu_done), .ex_illegal(ex_illegal)
  );

  ctrl_decode_pipe #(.ENABLE_M(1'b0), .MUL_LAT(2), .DIV_LAT(33)) dut_nm (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_in(stall_in), .flush(flush), .id_stall(nm_id_stall), .ex_valid(nm_ex_valid),
    .ex_regwrite(nm_ex_regwrite), .ex_alusrc(nm_ex_alusrc),
    .ex_pctoregsrc(nm_ex_pctoregsrc), .ex_rdsrc(nm_ex_rdsrc), .ex_mread(nm_ex_mread),
    .ex_mwrite(nm_ex_mwrite), .ex_memtoreg(nm_ex_memtoreg), .ex_aluop(nm_ex_aluop),
    .ex_branchctrl(nm_ex_branchctrl), .ex_immtype(nm_ex_immtype), .ex_rd(nm_ex_rd),
    .ex_mdu_op(nm_ex_mdu_op), .ex_mdu_done(nm_ex_mdu_done), .ex_illegal(nm_ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int stalls, dones, done_at, occ;

  initial begin
    rst_n    = 1'b0;
    id_valid = 1'b0;
    id_instr = '0;
    stall_in = 1'b0;
    flush    = 1'b0;

    // Reset state
    #12;
    check("rst ex_valid",    ex_valid,    0);
    check("rst ex_regwrite", ex_regwrite, 0);
    check("rst ex_rd",       ex_rd,       0);
    check("rst ex_mdu_done", ex_mdu_done, 0);
    check("rst ex_illegal",  ex_illegal,  0);
    check("rst id_stall",    id_stall,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    id_valid = 1'b1;
    id_instr = I_ADD_3_1_2;
    #1 check("add id_stall", id_stall, 0);
    tick();
    check("add ex_valid",    ex_valid,    1);
    check("add regwrite",    ex_regwrite, 1);
    check("add aluop",       ex_aluop,    3'b000);
    check("add rdsrc",       ex_rdsrc,    1);
    check("add pctoregsrc",  ex_pctoregsrc, 1);
    check("add immtype",     ex_immtype,  3'b111);
    check("add ex_rd",       ex_rd,       3);

    // LW x5 then dependent ADD: one stall, one bubble
    id_instr = I_LW_5;
    tick();
    check("lw mread",    ex_mread,    1);
    check("lw memtoreg", ex_memtoreg, 1);
    check("lw aluop",    ex_aluop,    3'b001);
    check("lw ex_rd",    ex_rd,       5);
    id_instr = I_ADD_6_5_2;
    #1 check("lu id_stall first", id_stall, 1);
    tick();
    check("lu bubble ex_valid", ex_valid,    0);
    check("lu bubble regwrite", ex_regwrite, 0);
    check("lu id_stall second", id_stall,    0);
    tick();
    check("lu add ex_valid", ex_valid, 1);
    check("lu add ex_rd",    ex_rd,    6);

    // Load to x0: no hazard
    id_instr = I_LW_0;
    tick();
    id_instr = I_ADD_6_0_2;
    #1 check("lw x0 id_stall", id_stall, 0);
    tick();
    check("lw x0 next ex_rd", ex_rd, 6);

    // Load followed by LUI to the same rd (no source): no hazard
    id_instr = I_LW_5;
    tick();
    id_instr = I_LUI_5;
    #1 check("lw lui id_stall", id_stall, 0);
    tick();
    check("lui aluop",  ex_aluop,  3'b100);
    check("lui rdsrc",  ex_rdsrc,  1);
    check("lui alusrc", ex_alusrc, 1);

    // DIV, 33 EX cycles
    id_instr = I_DIV;
    tick();
    id_instr = I_ADD_3_1_2;
    check("div mdu_op", ex_mdu_op, 1);
    check("div ex_rd",  ex_rd,     7);
    stalls = 0; dones = 0; done_at = 0;
    for (int c = 1; c <= 33; c++) begin
      if (id_stall) stalls++;
      if (ex_mdu_done) begin dones++; done_at = c; end
      tick();
    end
    check("div stall cycles", stalls,  32);
    check("div done count",   dones,   1);
    check("div done cycle",   done_at, 33);
    check("div next ex_rd",   ex_rd,   3);
    check("div next mdu_op",  ex_mdu_op, 0);

    // MUL, 2 EX cycles; illegal when ENABLE_M=0
    id_instr = I_MUL;
    tick();
    id_instr = I_ADD_3_1_2;
    check("mul mdu_op",       ex_mdu_op,      1);
    check("mul illegal",      ex_illegal,     0);
    check("nm mul illegal",   nm_ex_illegal,  1);
    check("nm mul regwrite",  nm_ex_regwrite, 0);
    check("nm mul mdu_op",    nm_ex_mdu_op,   0);
    stalls = 0; dones = 0; done_at = 0;
    for (int c = 1; c <= 2; c++) begin
      if (id_stall) stalls++;
      if (ex_mdu_done) begin dones++; done_at = c; end
      tick();
    end
    check("mul stall cycles", stalls,  1);
    check("mul done cycle",   done_at, 2);
    check("mul done count",   dones,   1);
    check("mul next ex_rd",   ex_rd,   3);

    // Flush in cycle 10 of a DIV
    id_instr = I_DIV;
    tick();
    id_instr = I_ADD_3_1_2;
    repeat (9) tick();
    flush = 1'b1;
    #1 check("flush id_stall", id_stall, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush ex_valid",  ex_valid,    0);
    check("flush mdu_done",  ex_mdu_done, 0);
    check("flush mdu_op",    ex_mdu_op,   0);
    check("flush idle stall", id_stall,   0);
    tick();
    check("post flush done",  ex_mdu_done, 0);
    check("post flush valid", ex_valid,    1);
    check("post flush ex_rd", ex_rd,       3);

    // Illegal encodings and a few legal control-flow / store rows
    id_instr = I_BAD_OP;
    tick();
    check("op7f illegal",    ex_illegal,    1);
    check("op7f regwrite",   ex_regwrite,   0);
    check("op7f mwrite",     ex_mwrite,     0);
    check("op7f branchctrl", ex_branchctrl, 0);
    check("op7f ex_rd",      ex_rd,         0);
    check("op7f ex_valid",   ex_valid,      1);
    id_instr = I_JALR_F1;
    tick();
    check("jalr f1 illegal",    ex_illegal,    1);
    check("jalr f1 regwrite",   ex_regwrite,   0);
    check("jalr f1 branchctrl", ex_branchctrl, 0);
    id_instr = I_JALR;
    tick();
    check("jalr illegal",    ex_illegal,    0);
    check("jalr branchctrl", ex_branchctrl, 3);
    check("jalr aluop",      ex_aluop,      3'b111);
    check("jalr immtype",    ex_immtype,    3'b001);
    id_instr = I_SW;
    tick();
    check("sw mwrite",   ex_mwrite,   1);
    check("sw regwrite", ex_regwrite, 0);
    check("sw aluop",    ex_aluop,    3'b010);
    check("sw immtype",  ex_immtype,  3'b010);
    check("sw ex_rd",    ex_rd,       4);

    // stall_in for 3 cycles during MUL: occupancy 2+3
    id_instr = I_MUL;
    tick();
    id_instr = I_ADD_3_1_2;
    occ = 0; dones = 0; done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      stall_in = (c <= 3);
      #1;
      if (c == 1) check("stall_in id_stall", id_stall, 1);
      if (c == 3) check("stall_in frozen rd", ex_rd, 10);
      if (ex_mdu_op) occ++;
      if (ex_mdu_done) begin dones++; done_at = c; end
      tick();
    end
    stall_in = 1'b0;
    check("stall_in occupancy", occ,     5);
    check("stall_in done count", dones,  1);
    check("stall_in done cycle", done_at, 5);

    // Asynchronous reset mid-DIV
    id_instr = I_DIV;
    tick();
    id_instr = I_ADD_3_1_2;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst ex_valid", ex_valid,    0);
    check("async rst mdu_op",   ex_mdu_op,   0);
    check("async rst ex_rd",    ex_rd,       0);
    check("async rst regwrite", ex_regwrite, 0);
    check("async rst id_stall", id_stall,    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
